// File: rtl/block_ram_banked.sv
// Multi-bank simple-dual-port block RAM with byte enables, selectable collision
// behaviour, optional output register and a zero-fill clear sequencer.
module block_ram_banked #(
    parameter int    DATA_WIDTH      = 32,
    parameter int    BYTE_WIDTH      = 8,
    parameter int    DEPTH           = 2**12,
    parameter int    NUM_BANKS       = 4,
    parameter string RAM_STYLE       = "auto",
    parameter string OUTPUT_REGISTER = "false",
    parameter string RW_MODE         = "read_first",
    localparam int   NBE             = DATA_WIDTH / BYTE_WIDTH,
    localparam int   AW              = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_BANKS-1:0]            wr_en,
    input  logic [NUM_BANKS*NBE-1:0]        wr_be,
    input  logic [NUM_BANKS*AW-1:0]         wr_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_BANKS-1:0]            rd_en,
    input  logic [NUM_BANKS*AW-1:0]         rd_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_BANKS-1:0]            rd_valid,
    input  logic                            clear,
    output logic                            busy
);

    // Reject configurations the datapath cannot represent.
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || NUM_BANKS < 1 ||
        !(RW_MODE == "read_first" || RW_MODE == "write_first") ||
        !(OUTPUT_REGISTER == "true" || OUTPUT_REGISTER == "false") ||
        !(RAM_STYLE == "auto" || RAM_STYLE == "block" || RAM_STYLE == "distributed" ||
          RAM_STYLE == "registers" || RAM_STYLE == "ultra" || RAM_STYLE == "mixed")) begin : g_param_error
        $error("block_ram_banked: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_addr_reg, clr_addr_next;
    logic            clr_last;

    assign clr_last = (clr_addr_reg == AW'(DEPTH - 1));
    assign busy     = (state_reg == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + AW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                clr_addr_next = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic                  bank_wr_en;
        logic [NBE-1:0]        bank_wr_be;
        logic [AW-1:0]         bank_wr_addr;
        logic [DATA_WIDTH-1:0] bank_wr_data;
        logic                  bank_rd_en;
        logic [AW-1:0]         bank_rd_addr;
        logic                  rd_accept;
        logic [DATA_WIDTH-1:0] rd_word;
        logic [DATA_WIDTH-1:0] rd_merged;
        logic [DATA_WIDTH-1:0] s1_data_reg;
        logic                  s1_valid_reg;

        (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        assign bank_wr_en   = wr_en[gi];
        assign bank_wr_be   = wr_be[gi*NBE +: NBE];
        assign bank_wr_addr = wr_addr[gi*AW +: AW];
        assign bank_wr_data = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign bank_rd_en   = rd_en[gi];
        assign bank_rd_addr = rd_addr[gi*AW +: AW];
        assign rd_accept    = bank_rd_en & ~busy;
        assign rd_word      = mem[bank_rd_addr];

        // The sweep owns the write port while busy; user writes are dropped.
        always_ff @(posedge clk) begin
            if (busy) begin
                mem[clr_addr_reg] <= '0;
            end else if (bank_wr_en) begin
                for (int i = 0; i < NBE; i++) begin
                    if (bank_wr_be[i]) begin
                        mem[bank_wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bank_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end

        if (RW_MODE == "write_first") begin : g_write_first
            always_comb begin
                rd_merged = rd_word;
                if (bank_wr_en && !busy && (bank_wr_addr == bank_rd_addr)) begin
                    for (int i = 0; i < NBE; i++) begin
                        if (bank_wr_be[i]) begin
                            rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bank_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                        end
                    end
                end
            end
        end else begin : g_read_first
            assign rd_merged = rd_word;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_data_reg  <= '0;
                s1_valid_reg <= 1'b0;
            end else begin
                s1_valid_reg <= rd_accept;
                if (rd_accept) begin
                    s1_data_reg <= rd_merged;
                end
            end
        end

        if (OUTPUT_REGISTER == "true") begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_data_reg;
            logic                  s2_valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_data_reg  <= '0;
                    s2_valid_reg <= 1'b0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data_reg;
                    end
                end
            end

            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = s2_data_reg;
            assign rd_valid[gi]                         = s2_valid_reg;
        end else begin : g_no_out_reg
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = s1_data_reg;
            assign rd_valid[gi]                         = s1_valid_reg;
        end
    end

endmodule

// File: tb/tb_block_ram_banked.sv
// Bench for block_ram_banked: two instances sharing stimulus, one read_first with
// latency 1 and one write_first with latency 2, checked against hand-computed vectors.
module tb_block_ram_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [7:0]  wr_be;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic        clear;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    block_ram_banked #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16), .NUM_BANKS(2),
        .RAM_STYLE("auto"), .OUTPUT_REGISTER("false"), .RW_MODE("read_first")
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .clear(clear), .busy(busy_a)
    );

    block_ram_banked #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16), .NUM_BANKS(2),
        .RAM_STYLE("block"), .OUTPUT_REGISTER("true"), .RW_MODE("write_first")
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .clear(clear), .busy(busy_b)
    );

    typedef struct {
        logic [1:0]  we;
        logic [7:0]  be;
        logic [7:0]  wa;
        logic [63:0] wd;
        logic [1:0]  re;
        logic [7:0]  ra;
        logic [1:0]  va;
        logic [63:0] da;
        logic [1:0]  vb;
        logic [63:0] db;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wr_en   = '0;
        wr_be   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        clear   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy_a"}, 64'(busy_a), 64'd0);
        check({tag, "_busy_b"}, 64'(busy_b), 64'd0);
        check({tag, "_valid_a"}, 64'(rd_valid_a), 64'd0);
        check({tag, "_valid_b"}, 64'(rd_valid_b), 64'd0);
        check({tag, "_data_a"}, rd_data_a, 64'd0);
        check({tag, "_data_b"}, rd_data_b, 64'd0);
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 2'b11;
            wr_be   = 8'hFF;
            wr_addr = {4'(i), 4'(i)};
            wr_data = {32'h5A5A0000 + 32'(i), 32'hA5A50001 + 32'(i)};
            step();
        end
        set_idle();
    endtask

    // Pulse clear and count the cycles busy stays high; optionally hammer the
    // write/read ports throughout the sweep to prove they are ignored.
    task automatic run_clear(input bit traffic, output int ncyc);
        clear = 1'b1;
        step();
        clear = 1'b0;
        if (traffic) begin
            wr_en   = 2'b11;
            wr_be   = 8'hFF;
            wr_addr = 8'h00;
            wr_data = '1;
            rd_en   = 2'b11;
            rd_addr = 8'h00;
        end
        ncyc = 0;
        while (busy_a === 1'b1 && ncyc < 100) begin
            ncyc++;
            check("sweep_busy_b", 64'(busy_b), 64'd1);
            if (traffic) begin
                check("sweep_valid_a", 64'(rd_valid_a), 64'd0);
                check("sweep_valid_b", 64'(rd_valid_b), 64'd0);
            end
            step();
        end
        check("sweep_end_busy_b", 64'(busy_b), 64'd0);
        set_idle();
    endtask

    task automatic readback_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_en   = 2'b11;
            rd_addr = {4'(i), 4'(i)};
            step();
            check({tag, "_valid_a"}, 64'(rd_valid_a), 64'h3);
            check({tag, "_data_a"}, rd_data_a, 64'd0);
            if (i > 0) begin
                check({tag, "_valid_b"}, 64'(rd_valid_b), 64'h3);
                check({tag, "_data_b"}, rd_data_b, 64'd0);
            end
        end
        set_idle();
        step();
        check({tag, "_valid_b"}, 64'(rd_valid_b), 64'h3);
        check({tag, "_data_b"}, rd_data_b, 64'd0);
    endtask

    initial begin
        int ncyc;

        //           we     be     wa     wd                      re     ra     va     da                      vb     db
        vecs[0]  = '{2'b01, 8'h0F, 8'h03, 64'h00000000_AABBCCDD, 2'b00, 8'h00, 2'b00, 64'h00000000_00000000, 2'b00, 64'h00000000_00000000};
        vecs[1]  = '{2'b01, 8'h05, 8'h03, 64'h00000000_11223344, 2'b00, 8'h00, 2'b00, 64'h00000000_00000000, 2'b00, 64'h00000000_00000000};
        vecs[2]  = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b01, 8'h03, 2'b01, 64'h00000000_AA22CC44, 2'b00, 64'h00000000_00000000};
        vecs[3]  = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b00, 8'h00, 2'b00, 64'h00000000_AA22CC44, 2'b01, 64'h00000000_AA22CC44};
        vecs[4]  = '{2'b01, 8'h03, 8'h05, 64'h00000000_FFFFFFFF, 2'b01, 8'h05, 2'b01, 64'h00000000_00000000, 2'b00, 64'h00000000_AA22CC44};
        vecs[5]  = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b01, 8'h05, 2'b01, 64'h00000000_0000FFFF, 2'b01, 64'h00000000_0000FFFF};
        vecs[6]  = '{2'b10, 8'hF0, 8'h70, 64'hDEADBEEF_00000000, 2'b00, 8'h00, 2'b00, 64'h00000000_0000FFFF, 2'b01, 64'h00000000_0000FFFF};
        vecs[7]  = '{2'b01, 8'h0F, 8'h07, 64'h00000000_12345678, 2'b10, 8'h70, 2'b10, 64'hDEADBEEF_0000FFFF, 2'b00, 64'h00000000_0000FFFF};
        vecs[8]  = '{2'b10, 8'hF0, 8'h70, 64'h55555555_00000000, 2'b01, 8'h07, 2'b01, 64'hDEADBEEF_12345678, 2'b10, 64'hDEADBEEF_0000FFFF};
        vecs[9]  = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b11, 8'h73, 2'b11, 64'h55555555_AA22CC44, 2'b01, 64'hDEADBEEF_12345678};
        vecs[10] = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b00, 8'h00, 2'b00, 64'h55555555_AA22CC44, 2'b11, 64'h55555555_AA22CC44};
        vecs[11] = '{2'b10, 8'h00, 8'h70, 64'h00000000_00000000, 2'b10, 8'h70, 2'b10, 64'h55555555_AA22CC44, 2'b00, 64'h55555555_AA22CC44};
        vecs[12] = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b10, 8'h70, 2'b10, 64'h55555555_AA22CC44, 2'b10, 64'h55555555_AA22CC44};
        vecs[13] = '{2'b00, 8'h00, 8'h00, 64'h00000000_00000000, 2'b00, 8'h00, 2'b00, 64'h55555555_AA22CC44, 2'b10, 64'h55555555_AA22CC44};

        set_idle();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-fill first so the array starts from known contents.
        run_clear(1'b0, ncyc);
        check("init_sweep_cycles", 64'(ncyc), 64'd16);
        $display("clear sweep: busy for %0d cycles", ncyc);

        for (int i = 0; i < 14; i++) begin
            wr_en   = vecs[i].we;
            wr_be   = vecs[i].be;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            rd_en   = vecs[i].re;
            rd_addr = vecs[i].ra;
            step();
            check($sformatf("vec%0d_valid_a", i), 64'(rd_valid_a), 64'(vecs[i].va));
            check($sformatf("vec%0d_data_a", i), rd_data_a, vecs[i].da);
            check($sformatf("vec%0d_valid_b", i), 64'(rd_valid_b), 64'(vecs[i].vb));
            check($sformatf("vec%0d_data_b", i), rd_data_b, vecs[i].db);
            $display("vec %0d: we=%b rd_en=%b -> a:%b/%h b:%b/%h", i, vecs[i].we, vecs[i].re,
                     rd_valid_a, rd_data_a, rd_valid_b, rd_data_b);
        end
        set_idle();

        // Asynchronous reset pulse between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsim_rst");
        $display("mid-sim reset: outputs a=%h b=%h busy=%b", rd_data_a, rd_data_b, busy_a);
        @(negedge clk);
        rst_n = 1'b1;

        fill();
        run_clear(1'b1, ncyc);
        check("traffic_sweep_cycles", 64'(ncyc), 64'd16);
        $display("clear sweep with dropped traffic: busy for %0d cycles", ncyc);
        readback_zero("rb1");
        $display("readback after sweep done");

        // Reset five cycles into a sweep, then a full fresh sweep.
        fill();
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (5) step();
        check("pre_abort_busy_a", 64'(busy_a), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        $display("reset mid-clear: busy=%b", busy_a);
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(1'b0, ncyc);
        check("post_abort_sweep_cycles", 64'(ncyc), 64'd16);
        $display("clear sweep after abort: busy for %0d cycles", ncyc);
        readback_zero("rb2");
        $display("readback after abort sweep done");

        // Access in the very first cycle after busy falls.
        run_clear(1'b0, ncyc);
        check("last_sweep_cycles", 64'(ncyc), 64'd16);
        wr_en   = 2'b01;
        wr_be   = 8'h0F;
        wr_addr = 8'h09;
        wr_data = 64'h00000000_CAFEBABE;
        rd_en   = 2'b01;
        rd_addr = 8'h09;
        step();
        set_idle();
        check("post_busy_valid_a", 64'(rd_valid_a), 64'h1);
        check("post_busy_data_a", rd_data_a, 64'h00000000_00000000);
        rd_en   = 2'b01;
        rd_addr = 8'h09;
        step();
        set_idle();
        check("post_busy_valid_b", 64'(rd_valid_b), 64'h1);
        check("post_busy_data_b", rd_data_b, 64'h00000000_CAFEBABE);
        check("post_busy_reread_a", rd_data_a, 64'h00000000_CAFEBABE);
        $display("first access after busy: a=%h b=%h", rd_data_a, rd_data_b);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/block_ram_banked.md
# block_ram_banked

Multi-bank block RAM with independent per-bank simple-dual-port access, byte write enables, a selectable read-during-write mode, a read-valid pipeline and a hardware clear sequencer. It extends the team's single-port block RAM for the feature-map and weight buffers, which need several parallel channels, partial-word updates and a fast zero-fill between frames. Each bank is one inferred RAM array; the array contents are never reset.

## Interface

- DATA_WIDTH, 32: word width per bank; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: byte-enable granularity; NBE = DATA_WIDTH/BYTE_WIDTH.
- DEPTH, 2**12: words per bank; AW = $clog2(DEPTH).
- NUM_BANKS, 4: number of independent banks; must be ≥ 1.
- RAM_STYLE, "auto": ram_style attribute applied to each bank array.
- OUTPUT_REGISTER, "false": "true" adds a second output register stage.
- RW_MODE, "read_first": "read_first" or "write_first"; defines same-address read/write collision behaviour.

Ports:

- clk, input, 1: single clock; all logic is on posedge.
- rst_n, input, 1: reset; **asynchronous, active-low**.
- wr_en, input, NUM_BANKS: per-bank write strobe.
- wr_be, input, NUM_BANKS*NBE: per-bank byte enables; bank b occupies slice [b*NBE +: NBE].
- wr_addr, input, NUM_BANKS*AW: per-bank write address.
- wr_data, input, NUM_BANKS*DATA_WIDTH: per-bank write data.
- rd_en, input, NUM_BANKS: per-bank read strobe.
- rd_addr, input, NUM_BANKS*AW: per-bank read address.
- rd_data, output, NUM_BANKS*DATA_WIDTH: per-bank read data.
- rd_valid, output, NUM_BANKS: per-bank one-cycle pulse marking fresh rd_data.
- clear, input, 1: request to zero-fill all banks.
- busy, output, 1: clear sequence in progress.

## Operation

- **Write.** On a clock edge with wr_en[b]=1 and busy=0, each byte i of bank b at wr_addr[b] is written where wr_be[b*NBE+i]=1. Other bytes are unchanged. wr_en[b]=1 with all byte enables 0 is a no-op.
- **Read.** On a clock edge with rd_en[b]=1 and busy=0, the stage-1 register loads the word at rd_addr[b]. When rd_en[b]=0, stage 1 holds its value.
- **Collision** (rd_en[b] and wr_en[b] both high, addresses equal, busy=0):
  - read_first: returns the old word.
  - write_first: returns the old word with the enabled bytes replaced by wr_data.
- **Bank independence.** Banks never interact. Any combination of per-bank enables is legal in the same cycle.
- **Clear state machine.** States are IDLE and CLEAR, with counter clr_addr of AW bits.
  - IDLE → CLEAR when clear=1 is sampled; clr_addr is set to 0.
  - In CLEAR, every bank writes all-zero at clr_addr each cycle, and clr_addr increments.
  - CLEAR → IDLE on the cycle clr_addr = DEPTH-1 is written.
  - clear is ignored while in CLEAR.
  - While busy=1, wr_en and rd_en are ignored and no new rd_valid is generated.
  - Reads accepted before busy rose still complete normally.
- **Reset.** Asynchronous assertion forces:
  - state to IDLE, busy=0, clr_addr=0;
  - rd_valid=0;
  - all rd_data stage registers to 0.
  
  Reset during CLEAR aborts the sweep, leaving array contents partially cleared and undefined to the user.

## Timing

- Read latency L is 1 (OUTPUT_REGISTER "false") or 2 ("true").
  - rd_data[b] is valid L cycles after the edge that sampled rd_en[b]=1.
  - rd_valid[b] pulses high in that same cycle for one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
- Stage 2, when present, loads stage 1 every cycle that stage-1 valid is high; otherwise it holds.
- rd_data holds its last value indefinitely between reads.
- busy rises on the edge after clear is sampled. It stays high for exactly DEPTH cycles and falls on the edge after the final clear write.
  - A write issued in the first cycle after busy falls is accepted.
  - A read issued in that cycle returns 0 or the new data, according to RW_MODE.
- clear and a user write in the same IDLE cycle: the user write is performed and the sweep starts next cycle, so the written location becomes 0.
- rst_n deassertion is synchronised by the user. The first legal access is on the edge after rst_n is seen high.

## Test plan

Bench configuration: NUM_BANKS=2, DATA_WIDTH=32, DEPTH=16 unless stated.

- **Reset values.** Pulse rst_n low mid-simulation → rd_data=0, rd_valid=0, busy=0 immediately; no clock edge is needed.
- **Byte enables and latency.** Bank0 writes 0xAABBCCDD at addr 3 with be=1111, then 0x11223344 at addr 3 with be=0101. Read addr 3 → 0xAA22CC44 with rd_valid after 1 cycle (OUTPUT_REGISTER "false") or 2 cycles ("true").
- **Collision.** Addr 5 holds 0x0; same-cycle write 0xFFFFFFFF (be=0011) and read of addr 5 → read_first returns 0x00000000, write_first returns 0x0000FFFF. A follow-up read returns 0x0000FFFF in both modes.
- **Bank independence.** Bank0 writes addr 7 = 0x12345678 while bank1 reads addr 7 (holding 0xDEADBEEF) in the same cycle → bank1 returns 0xDEADBEEF; bank0 is unaffected by bank1 traffic.
- **Clear sweep.** Fill both banks with nonzero data, pulse clear.
  - busy is high for exactly 16 cycles.
  - Writes and reads issued during busy are dropped, with no rd_valid.
  - All 32 words then read 0.
- **Reset mid-clear.** Assert rst_n low 5 cycles into CLEAR → busy=0 at once. After release, a new clear completes a full 16-cycle sweep and all words read 0.
